mem_wb_stage_buffer: RTL and testbench
======================================

Name: mem_wb_stage_buffer

Overview:
Parametrised MEM->WB pipeline stage with valid/ready flow control, replacing the plain freeze-only stage register. Holds up to two MEM results (output slot plus skid slot), so a WB-side stall never drops an in-flight result and in_ready depends only on registered state. Adds synchronous flush, selects the write-back value, and counts retired register writes for debug.

Parameters:
DATA_WIDTH, 32, width of ALU result, memory result and write-back value
DEST_WIDTH, 4, width of destination register index
CNT_WIDTH, 16, width of retired-write counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
freeze  in  1  global stall; blocks both handshakes
flush  in  1  synchronous flush of all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  buffer can accept an entry
wb_en_in  in  1  entry writes register file
mem_r_en_in  in  1  entry is a load
alu_res_in  in  DATA_WIDTH  ALU result
mem_res_in  in  DATA_WIDTH  memory read data
dest_in  in  DEST_WIDTH  destination register
out_valid  out  1  output slot holds an entry
out_ready  in  1  WB stage consumes entry
wb_en_out  out  1  wb_en of output entry, forced 0 when out_valid=0
mem_r_en_out  out  1  mem_r_en of output entry, forced 0 when out_valid=0
alu_res_out  out  DATA_WIDTH  ALU result of output entry
mem_res_out  out  DATA_WIDTH  memory data of output entry
dest_out  out  DEST_WIDTH  destination of output entry
wb_value  out  DATA_WIDTH  mem_r_en_out ? mem_res_out : alu_res_out (combinational from registers)
retired_cnt  out  CNT_WIDTH  count of out_fire with wb_en_out=1

Behaviour:
- Reset (rst=0, async): both slots invalid, all payload registers 0, retired_cnt=0; thus out_valid=0, in_ready=0 while rst=0, all outputs 0.
- in_ready = ~skid_valid & ~freeze & rst. Registered-state only; no combinational path from out_ready.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~freeze.
- States (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) unreachable.
- EMPTY: in_fire -> ONE, main<=in.
- ONE: in_fire & out_fire -> ONE, main<=in; in_fire & ~out_fire -> FULL, skid<=in; ~in_fire & out_fire -> EMPTY; else hold.
- FULL: in_ready=0; out_fire -> ONE, main<=skid; else hold.
- Latency: entry accepted at edge N is on outputs after edge N (out_valid=1 in cycle N+1 if buffer was EMPTY). Throughput 1 entry/cycle when out_ready=1.
- Ordering strictly FIFO; skid entry always emerges after main entry.
- freeze=1: no transfers, all registers hold, out_valid/payload keep presenting held entry.
- flush=1 (sync, highest priority, overrides freeze): next state EMPTY; entry offered in same cycle is discarded; payload registers may hold stale data but wb_en_out/mem_r_en_out read 0. retired_cnt does not increment in a flush cycle even if out_fire.
- retired_cnt: +1 on out_fire & wb_en_out & ~flush; wraps modulo 2^CNT_WIDTH.
- Invalid slots: payload is don't-care internally but gated control outputs guarantee no spurious write-back.
- Reset mid-operation: immediate clear regardless of state; held entries lost.

Test Plan:
- Reset then stream: rst 0->1, out_ready=1, push alu_res=0x11,0x22,0x33 dest=1,2,3 wb_en=1 on consecutive cycles -> same entries on outputs one cycle later each, in_ready stays 1, retired_cnt=3.
- Backpressure: out_ready=0, push A(0xAA), B(0xBB) -> FULL, in_ready=0, C held at input; release out_ready -> A, B, C emerge in order, none lost or duplicated.
- Load select: push mem_r_en=1, mem_res=0xDEADBEEF, alu_res=0x100 -> wb_value=0xDEADBEEF; mem_r_en=0 -> wb_value=0x100.
- Freeze: in FULL with out_ready=1, freeze=1 for 3 cycles -> outputs, state, retired_cnt unchanged, in_ready=0; freeze drop -> drain resumes.
- Flush: FULL plus in_valid=1 and flush=1 (also with freeze=1) -> next cycle out_valid=0, wb_en_out=0, in_ready=1, retired_cnt unchanged.
- Counter wrap and async reset: CNT_WIDTH=4, retire 17 wb_en=1 entries -> retired_cnt=1; assert rst between clock edges while FULL -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_wb_stage_buffer.sv
// MEM->WB pipeline stage: two-entry (output + skid) valid/ready buffer with
// synchronous flush, write-back value select and a retired-write counter.
module mem_wb_stage_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic [DATA_WIDTH-1:0] alu_res_in,
    input  logic [DATA_WIDTH-1:0] mem_res_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic [DATA_WIDTH-1:0] alu_res_out,
    output logic [DATA_WIDTH-1:0] mem_res_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic [DATA_WIDTH-1:0] wb_value,
    output logic [CNT_WIDTH-1:0]  retired_cnt
);

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DATA_WIDTH-1:0] alu_res;
        logic [DATA_WIDTH-1:0] mem_res;
        logic [DEST_WIDTH-1:0] dest;
    } entry_t;

    // Encoding is {main_valid, skid_valid}; (0,1) cannot occur.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_e;

    state_e                r_state;
    entry_t                r_main;
    entry_t                r_skid;
    logic [CNT_WIDTH-1:0]  r_retired_cnt;

    logic                  w_main_valid;
    logic                  w_skid_valid;
    logic                  w_in_fire;
    logic                  w_out_fire;
    entry_t                w_in_entry;

    assign w_main_valid = (r_state != S_EMPTY);
    assign w_skid_valid = (r_state == S_FULL);

    assign w_in_entry = '{
        wb_en:    wb_en_in,
        mem_r_en: mem_r_en_in,
        alu_res:  alu_res_in,
        mem_res:  mem_res_in,
        dest:     dest_in
    };

    // Accept decision uses registered state only, so out_ready never reaches in_ready.
    assign in_ready   = ~w_skid_valid & ~freeze & rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_main_valid & out_ready & ~freeze;

    // NOTE: payload registers are reset too so every output reads 0 during reset;
    // on a flush only the state is cleared and the control outputs are gated instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= S_EMPTY;
        end else begin
            // NOTE: non-blocking assignments let main<=skid and skid<=in read old values.
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_in_entry;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in_entry;
                    end else if (w_in_fire) begin
                        r_skid  <= w_in_entry;
                        r_state <= S_FULL;
                    end else if (w_out_fire) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired_cnt <= '0;
        end else if (w_out_fire && r_main.wb_en && !flush) begin
            r_retired_cnt <= r_retired_cnt + CNT_WIDTH'(1);
        end
    end

    assign out_valid    = w_main_valid;
    assign wb_en_out    = w_main_valid & r_main.wb_en;
    assign mem_r_en_out = w_main_valid & r_main.mem_r_en;
    assign alu_res_out  = r_main.alu_res;
    assign mem_res_out  = r_main.mem_res;
    assign dest_out     = r_main.dest;
    assign wb_value     = mem_r_en_out ? mem_res_out : alu_res_out;
    assign retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_mem_wb_stage_buffer.sv
// Randomised and directed bench for mem_wb_stage_buffer against a queue-based
// model of the two-entry FIFO stage and its retired-write counter.
module tb_mem_wb_stage_buffer;

    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic          wb_en;
        logic          mem_r_en;
        logic [DW-1:0] alu_res;
        logic [DW-1:0] mem_res;
        logic [RW-1:0] dest;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wb_en_in = 1'b0;
    logic          mem_r_en_in = 1'b0;
    logic [DW-1:0] alu_res_in = '0;
    logic [DW-1:0] mem_res_in = '0;
    logic [RW-1:0] dest_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          wb_en_out;
    logic          mem_r_en_out;
    logic [DW-1:0] alu_res_out;
    logic [DW-1:0] mem_res_out;
    logic [RW-1:0] dest_out;
    logic [DW-1:0] wb_value;
    logic [CW-1:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    ent_t          q[$];
    logic [CW-1:0] m_cnt = '0;
    logic [CW-1:0] saved_cnt;

    mem_wb_stage_buffer #(
        .DATA_WIDTH(DW),
        .DEST_WIDTH(RW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wb_en_in    (wb_en_in),
        .mem_r_en_in (mem_r_en_in),
        .alu_res_in  (alu_res_in),
        .mem_res_in  (mem_res_in),
        .dest_in     (dest_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wb_en_out   (wb_en_out),
        .mem_r_en_out(mem_r_en_out),
        .alu_res_out (alu_res_out),
        .mem_res_out (mem_res_out),
        .dest_out    (dest_out),
        .wb_value    (wb_value),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: at most two queued entries, oldest presented; a flush empties the queue.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_cnt = '0;
        end else begin
            logic rdy, in_f, out_f;
            ent_t e;
            rdy   = (q.size() < 2) && !freeze;
            in_f  = in_valid && rdy;
            out_f = (q.size() > 0) && out_ready && !freeze;
            e = '{wb_en_in, mem_r_en_in, alu_res_in, mem_res_in, dest_in};
            if (flush) begin
                q.delete();
            end else begin
                if (out_f) begin
                    if (q[0].wb_en) m_cnt = m_cnt + 1'b1;
                    void'(q.pop_front());
                end
                if (in_f) q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, (q.size() < 2) && !freeze && rst);
        check("out_valid", out_valid, q.size() > 0);
        check("retired_cnt", retired_cnt, m_cnt);
        if (q.size() > 0) begin
            check("wb_en_out", wb_en_out, q[0].wb_en);
            check("mem_r_en_out", mem_r_en_out, q[0].mem_r_en);
            check("alu_res_out", alu_res_out, q[0].alu_res);
            check("mem_res_out", mem_res_out, q[0].mem_res);
            check("dest_out", dest_out, q[0].dest);
            check("wb_value", wb_value, q[0].mem_r_en ? q[0].mem_res : q[0].alu_res);
        end else begin
            check("wb_en_out_idle", wb_en_out, 1'b0);
            check("mem_r_en_out_idle", mem_r_en_out, 1'b0);
        end
    end

    task automatic step(input logic v, input logic wb, input logic mr,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [RW-1:0] dst, input logic ordy,
                        input logic frz, input logic fl);
        @(posedge clk);
        #1;
        in_valid    = v;
        wb_en_in    = wb;
        mem_r_en_in = mr;
        alu_res_in  = alu;
        mem_res_in  = mem;
        dest_in     = dst;
        out_ready   = ordy;
        freeze      = frz;
        flush       = fl;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_retired", retired_cnt, 4'd0);
        check("rst_wb_value", wb_value, 32'd0);
        check("rst_dest", dest_out, 4'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;

        // Streaming at full throughput
        step(1, 1, 0, 32'h11, 0, 4'd1, 1, 0, 0);
        step(1, 1, 0, 32'h22, 0, 4'd2, 1, 0, 0);
        @(negedge clk);
        check("stream_first_alu", alu_res_out, 32'h11);
        check("stream_first_dest", dest_out, 4'd1);
        step(1, 1, 0, 32'h33, 0, 4'd3, 1, 0, 0);
        idle(1);
        idle(1);
        @(negedge clk);
        check("stream_retired", retired_cnt, 4'd3);
        check("stream_empty", out_valid, 1'b0);

        // Backpressure into FULL, then drain in order
        step(1, 1, 0, 32'hAA, 0, 4'd4, 0, 0, 0);
        step(1, 1, 0, 32'hBB, 0, 4'd5, 0, 0, 0);
        step(1, 1, 0, 32'hCC, 0, 4'd6, 0, 0, 0);
        @(negedge clk);
        check("bp_full_in_ready", in_ready, 1'b0);
        check("bp_head_alu", alu_res_out, 32'hAA);
        step(1, 1, 0, 32'hCC, 0, 4'd6, 1, 0, 0);
        step(1, 1, 0, 32'hCC, 0, 4'd6, 1, 0, 0);
        @(negedge clk);
        check("bp_second_alu", alu_res_out, 32'hBB);
        idle(1);
        @(negedge clk);
        check("bp_third_alu", alu_res_out, 32'hCC);
        idle(1);
        @(negedge clk);
        check("bp_drained", out_valid, 1'b0);

        // Write-back value select
        step(1, 1, 1, 32'h100, 32'hDEADBEEF, 4'd7, 0, 0, 0);
        idle(0);
        @(negedge clk);
        check("load_wb_value", wb_value, 32'hDEADBEEF);
        step(1, 1, 0, 32'h100, 32'hDEADBEEF, 4'd8, 1, 0, 0);
        idle(1);
        @(negedge clk);
        check("alu_wb_value", wb_value, 32'h100);
        idle(1);

        // Freeze while FULL with out_ready high
        step(1, 1, 0, 32'h51, 0, 4'd9, 0, 0, 0);
        step(1, 1, 0, 32'h52, 0, 4'd10, 0, 0, 0);
        step(1, 1, 0, 32'h53, 0, 4'd11, 1, 1, 0);
        saved_cnt = m_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_in_ready", in_ready, 1'b0);
            check("frz_head_alu", alu_res_out, 32'h51);
            check("frz_retired", retired_cnt, saved_cnt);
            if (i < 2) step(1, 1, 0, 32'h53, 0, 4'd11, 1, 1, 0);
        end
        step(1, 1, 0, 32'h53, 0, 4'd11, 1, 0, 0);
        idle(1);
        idle(1);
        idle(1);

        // Flush from FULL with an offered entry, without and with freeze
        for (int f = 0; f < 2; f++) begin
            step(1, 1, 1, 32'h61, 32'h71, 4'd12, 0, 0, 0);
            step(1, 1, 0, 32'h62, 32'h72, 4'd13, 0, 0, 0);
            step(1, 1, 0, 32'h63, 32'h73, 4'd14, 1, f[0], 1);
            saved_cnt = m_cnt;
            idle(0);
            @(negedge clk);
            check("flush_out_valid", out_valid, 1'b0);
            check("flush_wb_en", wb_en_out, 1'b0);
            check("flush_mem_r_en", mem_r_en_out, 1'b0);
            check("flush_in_ready", in_ready, 1'b1);
            check("flush_retired", retired_cnt, saved_cnt);
        end

        // Asynchronous reset between clock edges while FULL
        step(1, 1, 0, 32'h81, 0, 4'd1, 0, 0, 0);
        step(1, 1, 0, 32'h82, 0, 4'd2, 0, 0, 0);
        idle(0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_wb_en", wb_en_out, 1'b0);
        check("arst_alu", alu_res_out, 32'd0);
        check("arst_wb_value", wb_value, 32'd0);
        check("arst_retired", retired_cnt, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Counter wraps modulo 16
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0, $urandom, $urandom, RW'(i), 1, 0, 0);
        end
        idle(1);
        idle(1);
        @(negedge clk);
        check("wrap_retired", retired_cnt, 4'd1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, $urandom, $urandom,
                 RW'($urandom), ($urandom % 3) != 0, ($urandom % 8) == 0,
                 ($urandom % 32) == 0);
        end
        idle(1);
        idle(1);
        idle(1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
